// File: rtl/demux_pkg.sv
// Shared definitions for the lane mux/demux pair: lane count, lane pointer type,
// default byte width and the fill-state encoding used by the deserializer.
package demux_pkg;

   localparam int LANES              = 4;
   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef logic [1:0] lane_idx_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FILL  = 1'b1
   } fill_state_t;

   // The fill state is never stored separately; it is a view of the lane pointer.
   function automatic fill_state_t state_of(input lane_idx_t ptr);
      return (ptr == '0) ? ST_EMPTY : ST_FILL;
   endfunction

endpackage

// File: rtl/demux_flush_timer.sv
// Idle timer for a partially filled group: counts consecutive idle cycles while
// armed and pulses expire on the FLUSH_CYCLES-th one. FLUSH_CYCLES=0 disables it.
module demux_flush_timer
   import demux_pkg::*;
#(
   parameter int FLUSH_CYCLES = 16
) (
   input  logic aclk,
   input  logic reset_L,
   input  logic run,
   input  logic clr,
   output logic expire
);

   generate
      if (FLUSH_CYCLES == 0) begin : g_no_flush
         assign expire = 1'b0;
      end else begin : g_timer
         localparam int CW = $clog2(FLUSH_CYCLES + 1);
         localparam logic [CW-1:0] LAST_IDLE = CW'(FLUSH_CYCLES - 1);
         localparam logic [CW-1:0] SAT_IDLE  = CW'(FLUSH_CYCLES);

         logic [CW-1:0] idle_cnt_q;
         logic [CW-1:0] idle_cnt_d;

         assign expire = run && !clr && (idle_cnt_q == LAST_IDLE);

         always_comb begin
            idle_cnt_d = idle_cnt_q;
            if (clr || expire) begin
               idle_cnt_d = '0;
            end else if (run && (idle_cnt_q != SAT_IDLE)) begin
               idle_cnt_d = idle_cnt_q + CW'(1);
            end
         end

         always_ff @(posedge aclk or negedge reset_L) begin
            if (!reset_L) begin
               idle_cnt_q <= '0;
            end else begin
               idle_cnt_q <= idle_cnt_d;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/demux_l2_1to4.sv
// Receive-side deserializer: distributes a serial byte stream round-robin onto 4 lanes,
// delivering complete groups at once and flushing partial groups after an idle timeout.
module demux_l2_1to4
   import demux_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int FLUSH_CYCLES = 16
) (
   input  logic                  aclk,
   input  logic                  reset_L,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  valid_out0,
   output logic                  valid_out1,
   output logic                  valid_out2,
   output logic                  valid_out3,
   output logic [DATA_WIDTH-1:0] data_out0,
   output logic [DATA_WIDTH-1:0] data_out1,
   output logic [DATA_WIDTH-1:0] data_out2,
   output logic [DATA_WIDTH-1:0] data_out3,
   output logic                  busy
);

   localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

   lane_idx_t             ptr_q,  ptr_d;
   fill_state_t           state;
   logic [DATA_WIDTH-1:0] slot_q [LANES-1];
   logic [DATA_WIDTH-1:0] slot_d [LANES-1];
   logic [DATA_WIDTH-1:0] dout_q [LANES];
   logic [DATA_WIDTH-1:0] dout_d [LANES];
   logic [LANES-1:0]      vout_q, vout_d;
   logic                  busy_q;
   logic                  timer_run;
   logic                  timer_clr;
   logic                  flush;

   assign state     = state_of(ptr_q);
   assign timer_run = (state == ST_FILL) && !valid_in;
   assign timer_clr = valid_in || (state == ST_EMPTY);

   demux_flush_timer #(
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) u_flush_timer (
      .aclk    (aclk),
      .reset_L (reset_L),
      .run     (timer_run),
      .clr     (timer_clr),
      .expire  (flush)
   );

   always_comb begin
      ptr_d  = ptr_q;
      slot_d = slot_q;
      dout_d = dout_q;
      vout_d = '0;
      unique case (state)
         ST_EMPTY: begin
            if (valid_in) begin
               slot_d[0] = data_in;
               ptr_d     = lane_idx_t'(1);
            end
         end
         ST_FILL: begin
            if (valid_in) begin
               if (ptr_q == LAST_LANE) begin
                  for (int k = 0; k < LANES - 1; k++) begin
                     dout_d[k] = slot_q[k];
                  end
                  dout_d[LANES-1] = data_in;
                  vout_d          = '1;
                  ptr_d           = '0;
               end else begin
                  for (int k = 1; k < LANES - 1; k++) begin
                     if (ptr_q == lane_idx_t'(k)) begin
                        slot_d[k] = data_in;
                     end
                  end
                  ptr_d = ptr_q + lane_idx_t'(1);
               end
            end else if (flush) begin
               // Only the lanes already filled are delivered; the rest keep their old data.
               for (int k = 0; k < LANES - 1; k++) begin
                  if (lane_idx_t'(k) < ptr_q) begin
                     dout_d[k] = slot_q[k];
                     vout_d[k] = 1'b1;
                  end
               end
               ptr_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk or negedge reset_L) begin
      if (!reset_L) begin
         ptr_q  <= '0;
         vout_q <= '0;
         busy_q <= 1'b0;
         for (int k = 0; k < LANES - 1; k++) begin
            slot_q[k] <= '0;
         end
         for (int k = 0; k < LANES; k++) begin
            dout_q[k] <= '0;
         end
      end else begin
         ptr_q  <= ptr_d;
         vout_q <= vout_d;
         busy_q <= (ptr_d != '0);
         slot_q <= slot_d;
         dout_q <= dout_d;
      end
   end

   assign valid_out0 = vout_q[0];
   assign valid_out1 = vout_q[1];
   assign valid_out2 = vout_q[2];
   assign valid_out3 = vout_q[3];
   assign data_out0  = dout_q[0];
   assign data_out1  = dout_q[1];
   assign data_out2  = dout_q[2];
   assign data_out3  = dout_q[3];
   assign busy       = busy_q;

endmodule

// File: tb/tb_demux_l2_1to4.sv
// Bench for demux_l2_1to4: directed scenarios plus random traffic, every cycle compared
// against a queue-based reference model of the deserializer.
module tb_demux_l2_1to4;

   localparam int DW    = 8;
   localparam int FLUSH = 16;

   logic          aclk;
   logic          reset_L;
   logic          valid_in;
   logic [DW-1:0] data_in;
   logic          valid_out0, valid_out1, valid_out2, valid_out3;
   logic [DW-1:0] data_out0, data_out1, data_out2, data_out3;
   logic          busy;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [DW-1:0] pend_q[$];
   int            idle_run;
   logic [3:0]    exp_v;
   logic [DW-1:0] exp_d [4];

   demux_l2_1to4 #(
      .DATA_WIDTH   (DW),
      .FLUSH_CYCLES (FLUSH)
   ) dut (
      .aclk       (aclk),
      .reset_L    (reset_L),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .valid_out0 (valid_out0),
      .valid_out1 (valid_out1),
      .valid_out2 (valid_out2),
      .valid_out3 (valid_out3),
      .data_out0  (data_out0),
      .data_out1  (data_out1),
      .data_out2  (data_out2),
      .data_out3  (data_out3),
      .busy       (busy)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend_q.delete();
      idle_run = 0;
      exp_v    = '0;
      for (int i = 0; i < 4; i++) exp_d[i] = '0;
   endtask

   // One active edge of the model: bytes queue up, four make a group,
   // FLUSH idle edges with a partial group pending deliver what is there.
   task automatic model_edge(input logic v, input logic [DW-1:0] d);
      exp_v = '0;
      if (v) begin
         pend_q.push_back(d);
         idle_run = 0;
         if (pend_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
               exp_d[i] = pend_q[i];
               exp_v[i] = 1'b1;
            end
            pend_q.delete();
         end
      end else if (pend_q.size() != 0) begin
         idle_run++;
         if (idle_run == FLUSH) begin
            for (int i = 0; i < pend_q.size(); i++) begin
               exp_d[i] = pend_q[i];
               exp_v[i] = 1'b1;
            end
            pend_q.delete();
            idle_run = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 32'({valid_out3, valid_out2, valid_out1, valid_out0}), 32'(exp_v));
      chk({tag, ".d0"},    32'(data_out0), 32'(exp_d[0]));
      chk({tag, ".d1"},    32'(data_out1), 32'(exp_d[1]));
      chk({tag, ".d2"},    32'(data_out2), 32'(exp_d[2]));
      chk({tag, ".d3"},    32'(data_out3), 32'(exp_d[3]));
      chk({tag, ".busy"},  32'(busy),      32'(pend_q.size() != 0));
   endtask

   // Called at a negedge; drives, clocks, updates the model, checks at the next negedge.
   task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d);
      valid_in = v;
      data_in  = d;
      @(posedge aclk);
      model_edge(v, d);
      @(negedge aclk);
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 1'b0, '0);
   endtask

   initial begin
      logic [DW-1:0] b;
      int            n;
      reset_L  = 1'b0;
      valid_in = 1'b0;
      data_in  = '0;
      model_reset();
      repeat (3) @(negedge aclk);
      check_all("reset_init");
      reset_L = 1'b1;

      // Reset mid-group discards the partial group
      cycle("rst_pre", 1'b1, 8'hE1);
      cycle("rst_pre", 1'b1, 8'hE2);
      reset_L = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      repeat (2) @(negedge aclk);
      check_all("rst_hold");
      reset_L = 1'b1;
      for (int i = 1; i <= 4; i++) cycle("rst_post", 1'b1, 8'(i));
      chk("rst_post.d0_const", 32'(data_out0), 32'h01);
      chk("rst_post.d3_const", 32'(data_out3), 32'h04);
      idle("rst_post_idle", 1);

      // Full group
      for (int i = 0; i < 4; i++) cycle("full", 1'b1, 8'hA0 + 8'(i));
      chk("full.v_const", 32'({valid_out3, valid_out2, valid_out1, valid_out0}), 32'hF);
      chk("full.d2_const", 32'(data_out2), 32'hA2);
      idle("full_hold", 2);
      chk("full_hold.d1_const", 32'(data_out1), 32'hA1);

      // Back-to-back groups
      for (int i = 0; i < 8; i++) cycle("b2b", 1'b1, 8'h10 + 8'(i));
      chk("b2b.d0_const", 32'(data_out0), 32'h14);
      idle("b2b_tail", 2);

      // Gapped group below the timeout
      cycle("gap", 1'b1, 8'h55);
      idle("gap", 3);
      cycle("gap", 1'b1, 8'h66);
      idle("gap", 10);
      cycle("gap", 1'b1, 8'h77);
      cycle("gap", 1'b1, 8'h88);
      chk("gap.d1_const", 32'(data_out1), 32'h66);

      // Partial flush after exactly FLUSH idle edges
      cycle("pflush", 1'b1, 8'h11);
      cycle("pflush", 1'b1, 8'h22);
      idle("pflush", FLUSH);
      chk("pflush.v_const", 32'({valid_out3, valid_out2, valid_out1, valid_out0}), 32'h3);
      chk("pflush.busy_const", 32'(busy), 32'h0);
      idle("pflush_after", 2);

      // Byte arriving on the would-be expiry edge
      cycle("collide", 1'b1, 8'h11);
      idle("collide", FLUSH - 1);
      cycle("collide", 1'b1, 8'h33);
      idle("collide", FLUSH - 1);
      chk("collide.busy_const", 32'(busy), 32'h1);
      idle("collide_flush", 1);
      chk("collide.d1_const", 32'(data_out1), 32'h33);

      // Random traffic including long idle stretches
      for (int r = 0; r < 60; r++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle("rand_idle", $urandom_range(12, 20));
         end else begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
               b = 8'($urandom);
               cycle("rand", ($urandom_range(0, 9) < 7), b);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
